// File: rtl/switch_debouncer.sv
// Synchronises and debounces a vector of raw switch pins; emits clean level, press/release pulses and press counts.
// Optional long-press detection is built when SWITCH_DEBOUNCER_LONG_PRESS_EN is defined.
module switch_debouncer #(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = 600000,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int LONG_CYCLES     = 60000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_SW-1:0]     sw_in,
  output logic [NUM_SW-1:0]     sw_state,
  output logic [NUM_SW-1:0]     press_pulse,
  output logic [NUM_SW-1:0]     release_pulse,
  output logic [NUM_SW-1:0]     long_pulse,
  output logic [NUM_SW*8-1:0]   press_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          level;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          press_nxt;
    logic          release_nxt;
    logic          press_q;
    logic          release_q;
    logic [7:0]    count;

    // Sync flops idle at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1 <= ACTIVE_LOW;
        sync2 <= ACTIVE_LOW;
      end else begin
        sync1 <= sw_in[i];
        sync2 <= sync1;
      end
    end

    assign level = sync2 ^ ACTIVE_LOW;

    always_comb begin
      state_nxt   = state;
      cnt_nxt     = '0;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      unique case (state)
        RELEASED: begin
          if (level) begin
            state_nxt = PRESS_PEND;
            cnt_nxt   = cnt + CW'(1);
          end
        end
        PRESS_PEND: begin
          if (!level) begin
            state_nxt = RELEASED;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!level) begin
            state_nxt = REL_PEND;
            cnt_nxt   = cnt + CW'(1);
          end
        end
        REL_PEND: begin
          if (level) begin
            state_nxt = PRESSED;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = RELEASED;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = RELEASED;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= RELEASED;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        count     <= 8'd0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        if (press_nxt) begin
          count <= count + 8'd1;
        end
      end
    end

    assign sw_state[i]          = (state == PRESSED) || (state == REL_PEND);
    assign press_pulse[i]       = press_q;
    assign release_pulse[i]     = release_q;
    assign press_count[8*i +: 8] = count;

`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
    logic [HW-1:0] hold;
    logic          long_q;

    // Hold counter saturates so only one long pulse can fire per press.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= sw_state[i] && (hold == HOLD_PRE);
        if (!sw_state[i]) begin
          hold <= '0;
        end else if (hold != HOLD_MAX) begin
          hold <= hold + HW'(1);
        end
      end
    end

    assign long_pulse[i] = long_q;
`else
    assign long_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: expected pulses are queued with their due cycle and matched every cycle.
module tb_switch_debouncer;

  localparam int NSW  = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    sw_in;
  logic [1:0]    sw_state;
  logic [1:0]    press_pulse;
  logic [1:0]    release_pulse;
  logic [1:0]    long_pulse;
  logic [15:0]   press_count;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         press_seen[2] = '{0, 0};
  int         release_seen[2] = '{0, 0};
  int         long_seen[2] = '{0, 0};
  logic [7:0] model_count[2] = '{8'd0, 8'd0};
  logic [1:0] exp_press;
  logic [1:0] exp_release;
  logic [1:0] exp_long;

  switch_debouncer #(
    .NUM_SW(NSW),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW(1'b0),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_in(sw_in),
    .sw_state(sw_state),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle, retire events due now and require the pulse outputs to match exactly.
  always @(negedge clk) begin
    exp_press   = '0;
    exp_release = '0;
    exp_long    = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          0:       exp_press[sb[i].ch]   = 1'b1;
          1:       exp_release[sb[i].ch] = 1'b1;
          default: exp_long[sb[i].ch]    = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    checks++;
    if (press_pulse !== exp_press) begin
      failures++;
      $display("[TB] FAIL press_pulse cyc=%0d got=%b exp=%b", cyc, press_pulse, exp_press);
    end
    checks++;
    if (release_pulse !== exp_release) begin
      failures++;
      $display("[TB] FAIL release_pulse cyc=%0d got=%b exp=%b", cyc, release_pulse, exp_release);
    end
    checks++;
    if (long_pulse !== exp_long) begin
      failures++;
      $display("[TB] FAIL long_pulse cyc=%0d got=%b exp=%b", cyc, long_pulse, exp_long);
    end
    for (int c = 0; c < 2; c++) begin
      if (press_pulse[c] === 1'b1)   press_seen[c]++;
      if (release_pulse[c] === 1'b1) release_seen[c]++;
      if (long_pulse[c] === 1'b1)    long_seen[c]++;
    end
  end

  task automatic expect_event(input int due, input int ch, input int kind);
    ev_t e;
    e.cyc  = due;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
    if (kind == 0) model_count[ch] = model_count[ch] + 8'd1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sw_in   = 2'b00;
    model_count[0] = 8'd0;
    model_count[1] = 8'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sw_in   = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if (sw_state !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_sw_state got=%b exp=00", sw_state);
    end
    checks++;
    if (press_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_press_count got=%h exp=0000", press_count);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int n;
    @(negedge clk);
    n = cyc;
    sw_in[0] = 1'b1;
    expect_event(n + 6, 0, 0);
    repeat (8) begin
      @(negedge clk);
      if (cyc == n + 5) begin
        checks++;
        if (sw_state !== 2'b00) begin
          failures++;
          $display("[TB] FAIL clean_state_early got=%b exp=00", sw_state);
        end
      end
      if (cyc == n + 6) begin
        checks++;
        if (sw_state !== 2'b01) begin
          failures++;
          $display("[TB] FAIL clean_state_edge6 got=%b exp=01", sw_state);
        end
      end
    end
    checks++;
    if (press_count !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL clean_count got=%h exp=0001", press_count);
    end
    @(negedge clk);
    n = cyc;
    sw_in[0] = 1'b0;
    expect_event(n + 6, 0, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (sw_state !== 2'b00 || press_count !== {model_count[1], model_count[0]}) begin
      failures++;
      $display("[TB] FAIL clean_release state=%b count=%h exp_count=%h", sw_state, press_count,
               {model_count[1], model_count[0]});
    end
  endtask

  task automatic test_bounce();
    int n;
    logic [3:0] pattern;
    pattern = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sw_in[0] = pattern[k];
      @(negedge clk);
    end
    checks++;
    if (sw_state[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bounce_no_accept got=%b exp=0", sw_state[0]);
    end
    @(negedge clk);
    n = cyc;
    sw_in[0] = 1'b1;
    expect_event(n + 6, 0, 0);
    repeat (10) @(negedge clk);
    checks++;
    if (sw_state[0] !== 1'b1 || press_count[7:0] !== model_count[0]) begin
      failures++;
      $display("[TB] FAIL bounce_accept state=%b count=%0d exp_count=%0d", sw_state[0],
               press_count[7:0], model_count[0]);
    end
    @(negedge clk);
    n = cyc;
    sw_in[0] = 1'b0;
    expect_event(n + 6, 0, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_wrap();
    int n;
    int p0;
    int r0;
    p0 = press_seen[1];
    r0 = release_seen[1];
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        checks++;
        if (press_count[15:8] !== 8'd255) begin
          failures++;
          $display("[TB] FAIL wrap_before_last got=%0d exp=255", press_count[15:8]);
        end
      end
      @(negedge clk);
      n = cyc;
      sw_in[1] = 1'b1;
      expect_event(n + 6, 1, 0);
      repeat (8) @(negedge clk);
      @(negedge clk);
      n = cyc;
      sw_in[1] = 1'b0;
      expect_event(n + 6, 1, 1);
      repeat (8) @(negedge clk);
    end
    checks++;
    if (press_count[15:8] !== 8'd0) begin
      failures++;
      $display("[TB] FAIL wrap_final got=%0d exp=0", press_count[15:8]);
    end
    checks++;
    if ((press_seen[1] - p0) != 256 || (release_seen[1] - r0) != 256) begin
      failures++;
      $display("[TB] FAIL wrap_pulse_totals press=%0d release=%0d exp=256", press_seen[1] - p0,
               release_seen[1] - r0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    sw_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    model_count[0] = 8'd0;
    model_count[1] = 8'd0;
    @(negedge clk);
    checks++;
    if (sw_state !== 2'b00 || press_count !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_mid_clear state=%b count=%h exp=00/0000", sw_state, press_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = cyc;
    expect_event(n + 6, 0, 0);
    repeat (5) @(negedge clk);
    checks++;
    if (sw_state !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_mid_early got=%b exp=00", sw_state);
    end
    @(negedge clk);
    checks++;
    if (sw_state !== 2'b01) begin
      failures++;
      $display("[TB] FAIL reset_mid_accept got=%b exp=01", sw_state);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (press_count !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL reset_mid_count got=%h exp=0001", press_count);
    end
    @(negedge clk);
    n = cyc;
    sw_in[0] = 1'b0;
    expect_event(n + 6, 0, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int n;
    apply_reset();
    @(negedge clk);
    n = cyc;
    sw_in = 2'b11;
    expect_event(n + 6, 0, 0);
    expect_event(n + 6, 1, 0);
    repeat (8) @(negedge clk);
    checks++;
    if (sw_state !== 2'b11 || press_count !== 16'h0101) begin
      failures++;
      $display("[TB] FAIL simultaneous state=%b count=%h exp=11/0101", sw_state, press_count);
    end
    @(negedge clk);
    n = cyc;
    sw_in = 2'b00;
    expect_event(n + 6, 0, 1);
    expect_event(n + 6, 1, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_long_press();
    int n;
    int l0;
    int exp_longs;
    l0 = long_seen[0];
    @(negedge clk);
    n = cyc;
    sw_in[0] = 1'b1;
    expect_event(n + 6, 0, 0);
`ifdef SWITCH_DEBOUNCER_LONG_PRESS_EN
    expect_event(n + 6 + LONG, 0, 2);
    exp_longs = 1;
`else
    exp_longs = 0;
`endif
    repeat (46) @(negedge clk);
    n = cyc;
    sw_in[0] = 1'b0;
    expect_event(n + 6, 0, 1);
    repeat (8) @(negedge clk);
    @(negedge clk);
    n = cyc;
    sw_in[0] = 1'b1;
    expect_event(n + 6, 0, 0);
    repeat (16) @(negedge clk);
    sw_in[0] = 1'b0;
    expect_event(n + 22, 0, 1);
    repeat (30) @(negedge clk);
    checks++;
    if ((long_seen[0] - l0) != exp_longs) begin
      failures++;
      $display("[TB] FAIL long_pulse_total got=%0d exp=%0d", long_seen[0] - l0, exp_longs);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_reset_mid();
    test_simultaneous();
    test_long_press();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
